// File: rtl/tb_memory_regbus_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory_regbus_arb
// Brief    : Round-robin, transaction-locking arbiter that lets several regbus
//            requesters share one memory-model port, with saturating counters.
// Revision : 1.0 - initial release
// ============================================================================

package tb_memory_regbus_arb_pkg;
    localparam int ADDR_W = 48;
    localparam int DATA_W = 64;

    typedef struct packed {
        logic [ADDR_W-1:0]   addr;
        logic                write;
        logic [DATA_W-1:0]   wdata;
        logic [DATA_W/8-1:0] wstrb;
        logic                valid;
    } regbus_req_t;

    typedef struct packed {
        logic [DATA_W-1:0] rdata;
        logic              error;
        logic              ready;
    } regbus_rsp_t;
endpackage

module tb_memory_regbus_arb #(
    parameter int  NumReq    = 2,
    parameter int  AddrWidth = 48,
    parameter int  DataWidth = 64,
    parameter int  CntWidth  = 32,
    parameter type req_t     = tb_memory_regbus_arb_pkg::regbus_req_t,
    parameter type rsp_t     = tb_memory_regbus_arb_pkg::regbus_rsp_t
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  req_t [NumReq-1:0]               req_i,
    output rsp_t [NumReq-1:0]               rsp_o,
    output req_t                            req_o,
    input  rsp_t                            rsp_i,
    output logic [NumReq-1:0][CntWidth-1:0] gnt_cnt_o,
    output logic                            busy_o
);

    localparam int c_ptr_w    = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int c_req_bits = AddrWidth + 1 + DataWidth + DataWidth / 8 + 1;
    localparam int c_rsp_bits = DataWidth + 2;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t                           r_state;
    logic [c_ptr_w-1:0]               r_rr_ptr;
    logic [c_ptr_w-1:0]               r_gnt_q;
    logic [NumReq-1:0][CntWidth-1:0]  r_gnt_cnt;
    logic                             r_busy;

    logic                             w_any;
    logic [c_ptr_w-1:0]               w_winner;
    logic [c_ptr_w-1:0]               w_sel;
    logic                             w_active;
    logic                             w_done;
    req_t                             w_req;

    // Modular index (base + offset) mod NumReq; handles non-power-of-2 wrap.
    function automatic logic [c_ptr_w-1:0] next_idx(input logic [c_ptr_w-1:0] base,
                                                    input int                 offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NumReq) begin
            sum = sum - NumReq;
        end
        return c_ptr_w'(sum);
    endfunction

    always_comb begin
        w_any    = 1'b0;
        w_winner = r_rr_ptr;
        for (int k = 0; k < NumReq; k++) begin
            if (!w_any && req_i[next_idx(r_rr_ptr, k)].valid) begin
                w_any    = 1'b1;
                w_winner = next_idx(r_rr_ptr, k);
            end
        end
    end

    // In BUSY the grant is frozen; in IDLE the fresh winner is routed with no added latency.
    assign w_sel    = (r_state == ST_BUSY) ? r_gnt_q : w_winner;
    assign w_active = (r_state == ST_BUSY) || w_any;
    assign w_req    = w_active ? req_i[w_sel] : '0;
    assign w_done   = w_req.valid && rsp_i.ready;

    assign req_o     = w_req;
    assign gnt_cnt_o = r_gnt_cnt;
    assign busy_o    = r_busy;

    for (genvar g = 0; g < NumReq; g++) begin : g_rsp
        localparam logic [c_ptr_w-1:0] c_idx = c_ptr_w'(g);
        assign rsp_o[g] = (w_active && (w_sel == c_idx)) ? rsp_i : '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= ST_IDLE;
            r_rr_ptr  <= '0;
            r_gnt_q   <= '0;
            r_gnt_cnt <= '0;
            r_busy    <= 1'b0;
        end else begin
            if (w_done && (r_gnt_cnt[w_sel] != '1)) begin
                r_gnt_cnt[w_sel] <= r_gnt_cnt[w_sel] + CntWidth'(1);
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        if (rsp_i.ready) begin
                            r_rr_ptr <= next_idx(w_winner, 1);
                        end else begin
                            r_gnt_q <= w_winner;
                            r_state <= ST_BUSY;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                ST_BUSY: begin
                    if (w_done) begin
                        r_rr_ptr <= next_idx(r_gnt_q, 1);
                        r_state  <= ST_IDLE;
                        r_busy   <= 1'b0;
                    end else if (!w_req.valid) begin
                        // Abandoned transfer: release the port without advancing priority.
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    a_grant_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (r_state == ST_BUSY) |-> req_o.valid)
        else $error("granted requester dropped valid before ready");

    a_type_width: assert property (@(posedge clk_i)
        ($bits(req_t) == c_req_bits) && ($bits(rsp_t) == c_rsp_bits))
        else $error("req_t/rsp_t width does not match AddrWidth/DataWidth");

endmodule
`default_nettype wire

// File: tb/tb_tb_memory_regbus_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_tb_memory_regbus_arb
// Brief    : Directed self-checking bench for tb_memory_regbus_arb.
// Revision : 1.0 - initial release
// ============================================================================

module tb_tb_memory_regbus_arb;
    import tb_memory_regbus_arb_pkg::*;

    logic clk;
    logic rst_n;

    regbus_req_t [2:0] req3;
    regbus_rsp_t [2:0] rsp3_o;
    regbus_req_t       req3_o;
    regbus_rsp_t       rsp3_i;
    logic [2:0][31:0]  cnt3;
    logic              busy3;

    regbus_req_t [0:0] req1;
    regbus_rsp_t [0:0] rsp1_o;
    regbus_req_t       req1_o;
    regbus_rsp_t       rsp1_i;
    logic [0:0][1:0]   cnt1;
    logic              busy1;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [1:0]  sat_exp;
    logic [47:0] addr_tab [3] = '{48'h100, 48'h200, 48'h300};

    tb_memory_regbus_arb #(
        .NumReq   (3),
        .CntWidth (32)
    ) u_dut3 (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .req_i     (req3),
        .rsp_o     (rsp3_o),
        .req_o     (req3_o),
        .rsp_i     (rsp3_i),
        .gnt_cnt_o (cnt3),
        .busy_o    (busy3)
    );

    tb_memory_regbus_arb #(
        .NumReq   (1),
        .CntWidth (2)
    ) u_dut1 (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .req_i     (req1),
        .rsp_o     (rsp1_o),
        .req_o     (req1_o),
        .rsp_i     (rsp1_i),
        .gnt_cnt_o (cnt1),
        .busy_o    (busy1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input bit ok, input string tag);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $error("FAIL %s", tag);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drive3(input logic [2:0] valids);
        for (int i = 0; i < 3; i++) begin
            req3[i]       = '0;
            req3[i].addr  = addr_tab[i];
            req3[i].valid = valids[i];
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        req3   = '0;
        rsp3_i = '0;
        req1   = '0;
        rsp1_i = '0;
        rsp3_i.ready = 1'b1;
        rsp1_i.ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check(busy3 === 1'b0, "rst_busy");
        check(cnt3 === 96'd0, "rst_cnt3");
        check(req3_o === '0, "rst_req_o");
        check(rsp3_o[0].ready === 1'b0, "rst_rsp0_ready");
        check(cnt1 === 2'd0, "rst_cnt1");
        rst_n  = 1'b1;
        rsp3_i = '0;
        rsp1_i = '0;

        // Single read from requester 0, memory answers one cycle later
        tick();
        req3[0].addr  = 48'h1000;
        req3[0].valid = 1'b1;
        #1;
        check(req3_o.addr === 48'h1000, "t1_req_addr");
        check(busy3 === 1'b0, "t1_busy_pre");
        tick();
        rsp3_i.rdata = 64'hDEADBEEF;
        rsp3_i.ready = 1'b1;
        #1;
        check(busy3 === 1'b1, "t1_busy");
        check(rsp3_o[0].rdata === 64'hDEADBEEF, "t1_rdata");
        check(rsp3_o[1] === '0, "t1_rsp1_quiet");
        tick();
        req3   = '0;
        rsp3_i = '0;
        #1;
        check(busy3 === 1'b0, "t1_busy_post");
        check(cnt3[0] === 32'd1, "t1_cnt0");

        // Full contention, memory always ready: order 0,1,2,0,1,2
        do_reset();
        drive3(3'b111);
        rsp3_i.ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            check(req3_o.addr === addr_tab[k % 3], "t2_order");
            check(busy3 === 1'b0, "t2_busy");
            tick();
        end
        drive3(3'b000);
        rsp3_i = '0;
        #1;
        check(cnt3[0] === 32'd2, "t2_cnt0");
        check(cnt3[1] === 32'd2, "t2_cnt1");
        check(cnt3[2] === 32'd2, "t2_cnt2");

        // Non-power-of-2 wrap: move rr_ptr to 2, then only req 0 valid
        drive3(3'b010);
        rsp3_i.ready = 1'b1;
        #1;
        check(req3_o.addr === 48'h200, "t4_setup");
        tick();
        drive3(3'b001);
        #1;
        check(req3_o.addr === 48'h100, "t4_wrap_addr");
        check(rsp3_o[0].ready === 1'b1, "t4_wrap_ready");
        tick();
        drive3(3'b111);
        #1;
        check(req3_o.addr === 48'h200, "t4_ptr_is_1");
        tick();
        drive3(3'b000);
        rsp3_i = '0;

        // Lock: req 1 stalled, req 0 (higher priority at rr_ptr=2) waits
        drive3(3'b010);
        #1;
        check(req3_o.addr === 48'h200, "t3_grant");
        tick();
        drive3(3'b011);
        rsp3_i.rdata = 64'h55;
        rsp3_i.error = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check(req3_o.addr === 48'h200, "t3_lock_addr");
            check(rsp3_o[0] === '0, "t3_lock_rsp0");
            check(busy3 === 1'b1, "t3_lock_busy");
            tick();
        end
        rsp3_i.rdata = 64'hCAFE;
        rsp3_i.error = 1'b0;
        rsp3_i.ready = 1'b1;
        #1;
        check(rsp3_o[1].rdata === 64'hCAFE, "t3_done_rdata");
        check(rsp3_o[0] === '0, "t3_done_rsp0");
        tick();
        drive3(3'b001);
        rsp3_i = '0;
        #1;
        check(req3_o.addr === 48'h100, "t3_next_addr");
        check(busy3 === 1'b0, "t3_next_idle");
        tick();
        rsp3_i.ready = 1'b1;
        #1;
        check(rsp3_o[0].ready === 1'b1, "t3_next_ready");
        check(busy3 === 1'b1, "t3_next_busy");
        tick();
        drive3(3'b000);
        rsp3_i = '0;
        #1;
        check(cnt3[0] === 32'd4, "t3_cnt0");
        check(cnt3[1] === 32'd5, "t3_cnt1");
        check(cnt3[2] === 32'd2, "t3_cnt2");

        // Single requester pass-through with a 2-bit saturating counter
        req1[0].addr  = 48'h77;
        req1[0].valid = 1'b1;
        rsp1_i.ready  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            sat_exp = (k >= 3) ? 2'd3 : 2'(k);
            #1;
            check(req1_o.addr === 48'h77, "t5_pass_addr");
            check(rsp1_o[0].ready === 1'b1, "t5_pass_ready");
            check(cnt1[0] === sat_exp, "t5_cnt_step");
            tick();
        end
        req1   = '0;
        rsp1_i = '0;
        #1;
        check(cnt1[0] === 2'd3, "t5_cnt_sat");
        check(busy1 === 1'b0, "t5_busy1");

        // Reset while a transfer is stalled
        drive3(3'b100);
        #1;
        check(req3_o.addr === 48'h300, "t6_grant");
        tick();
        check(busy3 === 1'b1, "t6_busy_pre");
        rst_n = 1'b0;
        req3  = '0;
        #1;
        check(busy3 === 1'b0, "t6_busy");
        check(cnt3 === 96'd0, "t6_cnt3");
        check(req3_o.valid === 1'b0, "t6_valid");
        check(cnt1 === 2'd0, "t6_cnt1");
        tick();
        rst_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
